// File: rtl/smac_load_sequencer_if.sv
// smac_load_sequencer_if: operand stream, register-bank and datapath handshake bundle
interface smac_load_sequencer_if #(
    parameter int NREG = 8,
    parameter int M    = 16
);
    localparam int IW = $clog2(NREG);
    logic            start;
    logic [IW:0]     cfg_len;
    logic            abort;
    logic            in_valid;
    logic [M-1:0]    in_data;
    logic            in_ready;
    logic [M-1:0]    reg_wdata;
    logic [NREG-1:0] reg_w_en;
    logic [NREG-1:0] reg_cl_en;
    logic            bank_valid;
    logic [IW:0]     bank_len;
    logic            dp_ack;
    logic            busy;
    logic            err_len;
    modport master (
        output start, cfg_len, abort, in_valid, in_data, dp_ack,
        input  in_ready, reg_wdata, reg_w_en, reg_cl_en, bank_valid, bank_len, busy, err_len
    );
    modport slave (
        input  start, cfg_len, abort, in_valid, in_data, dp_ack,
        output in_ready, reg_wdata, reg_w_en, reg_cl_en, bank_valid, bank_len, busy, err_len
    );
endinterface

// File: rtl/smac_load_sequencer.sv
// smac_load_sequencer: sequences clear/write enables of an external input register bank
module smac_load_sequencer #(
    parameter int NREG = 8,
    parameter int M    = 16
) (
    input logic clk,
    input logic rst,
    smac_load_sequencer_if.slave bus
);
    localparam int IW = $clog2(NREG);
    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, VALID, DRAIN} state_t;
    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW:0]   len_q, len_d;
    logic          err_q, err_d;
    logic          xfer, len_ok, last;
    assign len_ok = (bus.cfg_len != '0) && (bus.cfg_len <= (IW+1)'(NREG));
    assign last   = {1'b0, idx_q} == len_q - 1'b1;
    assign bus.in_ready   = (state_q == LOAD) && !bus.abort;
    assign xfer           = bus.in_valid && bus.in_ready;
    assign bus.reg_wdata  = M'(bus.in_data);
    assign bus.reg_w_en   = xfer ? NREG'(1) << idx_q : '0;
    assign bus.reg_cl_en  = (state_q == CLEAR || state_q == DRAIN) ? '1 : '0;
    assign bus.bank_valid = state_q == VALID;
    assign bus.bank_len   = (state_q == VALID) ? len_q : '0;
    assign bus.busy       = state_q != IDLE;
    assign bus.err_len    = err_q;
    // next-state: abort outranks both ack and transfer; illegal lengths only raise err
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                if (len_ok) begin
                    len_d   = bus.cfg_len;
                    state_d = CLEAR;
                end else err_d = 1'b1;
            end
            CLEAR: begin
                idx_d   = '0;
                state_d = bus.abort ? DRAIN : LOAD;
            end
            LOAD: if (bus.abort) state_d = DRAIN;
                  else if (xfer) begin
                      idx_d   = idx_q + 1'b1;
                      state_d = last ? VALID : LOAD;
                  end
            VALID: state_d = (bus.abort || bus.dp_ack) ? DRAIN : VALID;
            DRAIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // controller state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end
endmodule
